inst_cache: RTL and testbench
=============================

// Module: inst_cache
// PURPOSE
//  Direct-mapped, read-only instruction cache between the pipeline fetch port (pc/instr) and a
//  slow word-wide instruction memory. Hits return instr combinationally in the same cycle.
//  Misses raise stall_o, which the pipeline ORs into stallF/stallD, and refill one full line.
//  Hit/miss counters expose fetch efficiency to the testbench.
// PARAMETERS
//  INDEX_BITS  6  number of lines = 2**INDEX_BITS
//  WORD_BITS   2  words per line = 2**WORD_BITS
//  Derived: TAG_BITS = 30 - INDEX_BITS - WORD_BITS
// PORTS
//  clk         in   1   clock, all state updates on rising edge
//  rst         in   1   synchronous reset, active-high
//  cpu_req     in   1   fetch valid this cycle
//  cpu_addr    in   32  fetch byte address (pc); bits [1:0] ignored
//  cpu_instr   out  32  instruction word, valid when cpu_req & ~stall_o
//  stall_o     out  1   fetch not satisfied this cycle; caller holds cpu_addr
//  inv_all     in   1   invalidate all lines (fence.i-style)
//  mem_req     out  1   refill word request, held until mem_ack
//  mem_addr    out  32  word-aligned refill address
//  mem_ack     in   1   mem_rdata valid; consumes the current request
//  mem_rdata   in   32  refill data
//  hit_cnt     out  32  completed hits (wraps at 2**32)
//  miss_cnt    out  32  misses started (wraps at 2**32)
// BEHAVIOUR
//  Address split: tag = addr[31:32-TAG_BITS], index = next INDEX_BITS, word = next WORD_BITS.
//  Arrays: valid[] (flops), tag[] and data[] (flops/distributed RAM), async read.
//  Reset: valid[] = 0, state = IDLE, cnt = 0, inv_pend = 0, hit_cnt = 0, miss_cnt = 0,
//   mem_req = 0, mem_addr = 0, stall_o = 0. cpu_instr is combinational from data[]; reset does
//   not clear it, and it is don't-care while the line is invalid.
//  hit = cpu_req & valid[index] & (tag[index] == tag(cpu_addr)) & (state == IDLE).
//  stall_o = cpu_req & ~hit. This is combinational and covers the miss cycle, REFILL, and DONE.
//  cpu_req = 0: stall_o = 0, no counter change, no miss.
//  States:
//   IDLE:   on hit, hit_cnt++. On cpu_req & ~hit, latch line base = {cpu_addr[31:2+WORD_BITS],0},
//           cnt = 0, miss_cnt++, set mem_req = 1 with mem_addr = base, and go to REFILL.
//   REFILL: mem_req = 1, mem_addr = base + 4*cnt. On mem_ack: data[idx][cnt] = mem_rdata
//           and cnt++. On the ack where cnt == 2**WORD_BITS-1: write tag[idx] and set
//           valid[idx] = ~inv_pend, drop mem_req in the same edge, and go to DONE.
//           A new request is issued the cycle after each non-final ack; mem_req stays high.
//   DONE:   one bubble cycle with stall_o still high; go to IDLE. The fetch then re-looks-up
//           and hits, unless invalidated.
//  Miss latency: 1 (IDLE) + sum of per-word ack latencies + 1 (DONE). With mem_ack on the
//   first cycle of every request and 4 words, stall_o is high for 6 cycles.
//  Refill address uses the latched base, never live cpu_addr. A cpu_addr change mid-refill is
//   a caller protocol violation and must not corrupt the line being filled.
//  inv_all in IDLE: all valid[] cleared at the edge, and a hit in that same cycle still
//   returns data. inv_all in REFILL/DONE: set inv_pend so the filling line ends invalid; clear
//   valid[] immediately; clear inv_pend on return to IDLE.
//  mem_ack while mem_req = 0: ignored.
//  rst mid-refill: abort; mem_req = 0 on the next cycle; partially written line stays invalid.
//   Memory must drop any outstanding request on rst.
//  Counters: plain 32-bit wrap, no saturation.
// TESTING
//  1 Cold miss: rst, then cpu_addr=0x0000_0040 and mem_ack each cycle with rdata=addr^0xA5A5_0000
//    -> mem_addr 0x40,0x44,0x48,0x4C, stall_o high 6 cycles, then instr=0xA5A5_0040 and
//    miss_cnt=1.
//  2 Line hits: after scenario 1, fetch 0x44, 0x48, 0x4C -> stall_o=0 each cycle, instr matches,
//    hit_cnt=3 (4 counting the post-refill 0x40 hit).
//  3 Conflict: fetch 0x40, then 0x40+(4<<(INDEX_BITS+WORD_BITS))=0x440, then 0x40
//    -> three misses, miss_cnt=3, and the third refill fetches 0x40..0x4C again.
//  4 Slow memory: mem_ack delayed 3 cycles per word -> mem_req/mem_addr stable while waiting,
//    stall_o high 1+16+1=18 cycles, data correct.
//  5 Invalidate mid-refill: assert inv_all during the 2nd word -> refill completes, the fetch
//    misses again after DONE, and miss_cnt increments by 2 in total.
//  6 Reset mid-refill: rst after the 2nd ack -> next cycle mem_req=0, counters=0; the next
//    fetch of the same address misses and refills all 4 words.

Source files
------------

// File: rtl/inst_cache.sv
`default_nettype none
// ============================================================================
//  Module      : inst_cache
//  Description : Direct-mapped, read-only instruction cache. Hits return the
//                instruction combinationally; misses stall the fetch and
//                refill one full line word-by-word from a slow memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_cache #(
    parameter int INDEX_BITS = 6,
    parameter int WORD_BITS  = 2
) (
    input  logic        clk,
    input  logic        rst,
    // fetch port
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    output logic [31:0] cpu_instr,
    output logic        stall_o,
    input  logic        inv_all,
    // refill port
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    // statistics
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
);

    localparam int c_TAG_BITS  = 30 - INDEX_BITS - WORD_BITS;
    localparam int c_LINE_BITS = 30 - WORD_BITS;       // line address width (tag + index)
    localparam int c_LINES     = 1 << INDEX_BITS;
    localparam int c_WORDS     = 1 << WORD_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Line storage: valid bits are resettable flops, tag/data are plain arrays.
    logic [c_LINES-1:0]    r_valid;
    logic [c_TAG_BITS-1:0] r_tag  [c_LINES];
    logic [31:0]           r_data [c_LINES*c_WORDS];

    state_t                r_state;
    logic [WORD_BITS-1:0]  r_cnt;
    logic                  r_invPend;
    logic [c_LINE_BITS-1:0] r_lineAddr;   // latched line base of the refill in flight

    logic [c_TAG_BITS-1:0] w_tag;
    logic [INDEX_BITS-1:0] w_index;
    logic [WORD_BITS-1:0]  w_word;
    logic [INDEX_BITS-1:0] w_fillIdx;
    logic [c_TAG_BITS-1:0] w_fillTag;
    logic [WORD_BITS-1:0]  w_nextCnt;
    logic                  w_hit;
    logic                  w_ackFire;
    logic                  w_lastWord;
    logic                  w_unused;

    // Fetch address split; byte offset bits are meaningless for word fetches.
    assign w_tag    = cpu_addr[31 -: c_TAG_BITS];
    assign w_index  = cpu_addr[2+WORD_BITS +: INDEX_BITS];
    assign w_word   = cpu_addr[2 +: WORD_BITS];
    assign w_unused = ^cpu_addr[1:0];

    // Refill target always comes from the latched base, never the live pc.
    assign w_fillIdx  = r_lineAddr[INDEX_BITS-1:0];
    assign w_fillTag  = r_lineAddr[c_LINE_BITS-1:INDEX_BITS];
    assign w_nextCnt  = r_cnt + 1'b1;
    assign w_lastWord = (r_cnt == {WORD_BITS{1'b1}});
    assign w_ackFire  = (r_state == ST_REFILL) & mem_req & mem_ack;

    // Lookups only hit while idle so a line under refill is never returned early.
    assign w_hit     = cpu_req & r_valid[w_index] & (r_tag[w_index] == w_tag) & (r_state == ST_IDLE);
    assign stall_o   = cpu_req & ~w_hit;
    assign cpu_instr = r_data[{w_index, w_word}];

    // Control FSM, valid bits, refill request and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_invPend  <= 1'b0;
            r_lineAddr <= '0;
            r_valid    <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            // Invalidate takes effect at this edge in every state; the fill
            // below may still override the one line it completes.
            if (inv_all) begin
                r_valid <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_hit) begin
                        hit_cnt <= hit_cnt + 32'd1;
                    end else if (cpu_req) begin
                        r_lineAddr <= cpu_addr[31:2+WORD_BITS];
                        r_cnt      <= '0;
                        miss_cnt   <= miss_cnt + 32'd1;
                        mem_req    <= 1'b1;
                        mem_addr   <= {cpu_addr[31:2+WORD_BITS], {(WORD_BITS+2){1'b0}}};
                        r_state    <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (inv_all) begin
                        r_invPend <= 1'b1;
                    end
                    if (w_ackFire) begin
                        if (w_lastWord) begin
                            // An invalidate seen at any point of the fill leaves the line invalid.
                            r_valid[w_fillIdx] <= ~(r_invPend | inv_all);
                            mem_req            <= 1'b0;
                            r_state            <= ST_DONE;
                        end else begin
                            r_cnt    <= w_nextCnt;
                            mem_addr <= {r_lineAddr, w_nextCnt, 2'b00};
                        end
                    end
                end
                ST_DONE: begin
                    r_invPend <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag and data arrays are written by refill acks only and need no reset.
    always_ff @(posedge clk) begin
        if (w_ackFire && !rst) begin
            r_data[{w_fillIdx, r_cnt}] <= mem_rdata;
            if (w_lastWord) begin
                r_tag[w_fillIdx] <= w_fillTag;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_cache.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_cache
//  Description : Self-checking bench for inst_cache with a randomized-latency
//                memory responder and a line-level reference cache model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_instr;
    logic        stall_o;
    logic        inv_all;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    inst_cache dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_instr (cpu_instr),
        .stall_o   (stall_o),
        .inv_all   (inv_all),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: one valid bit and tag per line; data is a pure function of address.
    bit          mValid [64];
    logic [31:0] mTag   [64];
    int          expHits   = 0;
    int          expMisses = 0;

    // Memory responder state.
    int          latMin = 0;
    int          latMax = 0;
    int          waitLeft = -1;
    int          refillTotal = 0;
    logic [31:0] reqAddr;
    logic [31:0] addrQ [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic modelClear();
        for (int i = 0; i < 64; i++) mValid[i] = 1'b0;
    endtask

    // Memory: each request waits a random number of cycles, then acks once.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rst || !mem_req) begin
                waitLeft  = -1;
                // stray acks with no request outstanding must be ignored
                mem_ack   = ($urandom_range(0, 3) == 0);
                mem_rdata = $urandom;
            end else begin
                if (waitLeft < 0) begin
                    waitLeft     = $urandom_range(latMin, latMax);
                    reqAddr      = mem_addr;
                    refillTotal += waitLeft + 1;
                end else begin
                    chk("memAddrStable", mem_addr, reqAddr);
                end
                if (waitLeft == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = memf(mem_addr);
                    addrQ.push_back(mem_addr);
                    waitLeft  = -1;
                end else begin
                    waitLeft--;
                end
            end
        end
    end

    // One fetch held until satisfied; optional invalidate on the first cycle
    // or during the second refill word.
    task automatic doFetch(input logic [31:0] a, input bit invIdle, input bit invMid,
                           output int stallOut);
        int          idx;
        logic [31:0] tg;
        bit          expHit;
        int          expMiss;
        int          refillStart;
        int          stall;
        int          acks;
        bit          inj;
        bit          done;
        idx         = int'((a >> 4) & 32'd63);
        tg          = a >> 10;
        expHit      = mValid[idx] && (mTag[idx] == tg);
        expMiss     = expHit ? 0 : (invMid ? 2 : 1);
        refillStart = refillTotal;
        stall = 0; acks = 0; inj = 0; done = 0;
        addrQ.delete();
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = a | ($urandom & 32'd3);
        inv_all  = invIdle;
        while (!done) begin
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
            if (!stall_o) begin
                done = 1;
                chk("instr", cpu_instr, memf(a));
            end else begin
                stall++;
                if (stall > 400) begin
                    chk("stallTimeout", stall, 0);
                    done = 1;
                end else begin
                    @(posedge clk);
                    #1;
                    inv_all = invMid && (acks == 1) && !inj;
                    if (inv_all) inj = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        inv_all = 1'b0;
        if (invIdle) modelClear();
        if (!expHit) begin
            if (invMid) modelClear();
            mValid[idx] = 1'b1;
            mTag[idx]   = tg;
        end
        expHits   += 1;
        expMisses += expMiss;
        @(negedge clk);
        chk("stallCycles", stall, expHit ? 0 : 2 * expMiss + (refillTotal - refillStart));
        chk("refillWords", addrQ.size(), 4 * expMiss);
        for (int i = 0; i < addrQ.size(); i++)
            chk("refillAddr", addrQ[i], (a & ~32'hF) + 32'(4 * (i % 4)));
        chk("hitCnt", hit_cnt, expHits);
        chk("missCnt", miss_cnt, expMisses);
        chk("memReqIdle", mem_req, 0);
        stallOut = stall;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cpu_req  = 1'b0;
            cpu_addr = $urandom;
            @(negedge clk);
            chk("idleStall", stall_o, 0);
            chk("idleMiss", miss_cnt, expMisses);
        end
    endtask

    // Reset asserted right after the second refill ack of a miss.
    task automatic rstMidRefill(input logic [31:0] a);
        int acks;
        int guard;
        int st;
        acks = 0; guard = 0;
        @(posedge clk);
        #1;
        cpu_req  = 1'b1;
        cpu_addr = a;
        while (acks < 2 && guard < 200) begin
            @(negedge clk);
            if (mem_req && mem_ack) acks++;
            guard++;
        end
        chk("rstAcks", acks, 2);
        @(posedge clk);
        #1;
        rst     = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstMemReq", mem_req, 0);
        chk("rstHitCnt", hit_cnt, 0);
        chk("rstMissCnt", miss_cnt, 0);
        chk("rstStall", stall_o, 0);
        modelClear();
        expHits = 0; expMisses = 0;
        doFetch(a, 0, 0, st);
    endtask

    initial begin
        int st;
        logic [31:0] a;
        rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; inv_all = 1'b0;
        modelClear();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstMemReq0", mem_req, 0);
        chk("rstMemAddr0", mem_addr, 0);
        chk("rstStall0", stall_o, 0);
        chk("rstHit0", hit_cnt, 0);
        chk("rstMiss0", miss_cnt, 0);

        // cold miss with immediate acks, then line hits
        latMin = 0; latMax = 0;
        doFetch(32'h40, 0, 0, st);
        chk("coldStall", st, 6);
        doFetch(32'h44, 0, 0, st);
        doFetch(32'h48, 0, 0, st);
        doFetch(32'h4C, 0, 0, st);
        chk("lineHits", hit_cnt, 4);
        idleCycles(3);

        // conflict on the same index
        doFetch(32'h440, 0, 0, st);
        doFetch(32'h40, 0, 0, st);
        chk("conflictMiss", miss_cnt, 3);

        // slow memory
        latMin = 3; latMax = 3;
        doFetch(32'h1000, 0, 0, st);
        chk("slowStall", st, 18);

        // invalidate during the second refill word, and on a hit cycle
        latMin = 0; latMax = 2;
        doFetch(32'h2000, 0, 1, st);
        doFetch(32'h2004, 1, 0, st);
        doFetch(32'h2008, 0, 0, st);

        rstMidRefill(32'h3000);

        // randomized traffic over a small conflicting address pool
        latMin = 0;
        for (int n = 0; n < 120; n++) begin
            latMax = $urandom_range(0, 3);
            a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 5)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            doFetch(a, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, st);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
